// File: rtl/drive_sequencer.sv
// Two-motor H-bridge drive sequencer: cruise with veer correction, collision recovery, junction turns,
// with a dead-time before every reversal. Optional macro DRIVE_SEQ_PIVOT_ALT_EN alternates recovery pivots.
module drive_sequencer #(
  parameter int DEAD_CYCLES    = 50_000,
  parameter int REVERSE_CYCLES = 25_000_000,
  parameter int PIVOT_CYCLES   = 20_000_000,
  parameter int TURN_CYCLES    = 30_000_000,
  parameter int TIMER_W        = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       collision,
  input  logic       veerLeft,
  input  logic       veerRight,
  input  logic       junction,
  input  logic       turnDir,
  input  logic       pwmFull,
  input  logic       pwmVeer,
  output logic       hbEnA,
  output logic       hbEnB,
  output logic       hbIn1,
  output logic       hbIn2,
  output logic       hbIn3,
  output logic       hbIn4,
  output logic [2:0] seqState,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FWD  = 3'd1,
    S_DEAD = 3'd2,
    S_REV  = 3'd3,
    S_PIV  = 3'd4
  } state_t;

  localparam logic [TIMER_W-1:0] DEAD_LD = TIMER_W'(DEAD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REV_LD  = TIMER_W'(REVERSE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] PIV_LD  = TIMER_W'(PIVOT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TURN_LD = TIMER_W'(TURN_CYCLES - 1);

  localparam logic [3:0] PAT_FWD  = 4'b0110;
  localparam logic [3:0] PAT_REV  = 4'b1001;
  localparam logic [3:0] PAT_PIVL = 4'b1010;
  localparam logic [3:0] PAT_PIVR = 4'b0101;

  state_t             state_q, state_d;
  state_t             nxt_q, nxt_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] plen_q, plen_d;
  logic               pdir_q, pdir_d;   // direction of the pending/active pivot, 1 = right
  logic               pivot_dir;        // direction the next collision recovery will pivot

`ifdef DRIVE_SEQ_PIVOT_ALT_EN
  logic pivot_dir_q, pivot_dir_d;
  logic rec_q, rec_d;                   // pending pivot belongs to a collision recovery
  assign pivot_dir = pivot_dir_q;
`else
  assign pivot_dir = 1'b1;
`endif

  logic       en_a_q, en_a_d, en_b_q, en_b_d;
  logic [3:0] pat_q, pat_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    nxt_d   = nxt_q;
    timer_d = timer_q;
    plen_d  = plen_q;
    pdir_d  = pdir_q;
`ifdef DRIVE_SEQ_PIVOT_ALT_EN
    pivot_dir_d = pivot_dir_q;
    rec_d       = rec_q;
`endif
    if (!enable) begin
      // Off is always safe, so drop straight to IDLE and forget any pending manoeuvre.
      state_d = S_IDLE;
      nxt_d   = S_FWD;
      timer_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_FWD;
          timer_d = '0;
        end
        S_FWD: begin
          if (collision) begin
            state_d = S_DEAD;
            timer_d = DEAD_LD;
            nxt_d   = S_REV;
          end else if (junction) begin
            state_d = S_DEAD;
            timer_d = DEAD_LD;
            nxt_d   = S_PIV;
            pdir_d  = turnDir;
            plen_d  = TURN_LD;
`ifdef DRIVE_SEQ_PIVOT_ALT_EN
            rec_d   = 1'b0;
`endif
          end
        end
        S_DEAD: begin
          if (timer_q == '0) begin
            state_d = nxt_q;
            case (nxt_q)
              S_REV:   timer_d = REV_LD;
              S_PIV:   timer_d = plen_q;
              default: timer_d = '0;
            endcase
`ifdef DRIVE_SEQ_PIVOT_ALT_EN
            if (nxt_q == S_PIV && rec_q) pivot_dir_d = ~pivot_dir_q;
`endif
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_REV: begin
          if (timer_q == '0) begin
            state_d = S_DEAD;
            timer_d = DEAD_LD;
            nxt_d   = S_PIV;
            pdir_d  = pivot_dir;
            plen_d  = PIV_LD;
`ifdef DRIVE_SEQ_PIVOT_ALT_EN
            rec_d   = 1'b1;
`endif
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        S_PIV: begin
          if (timer_q == '0) begin
            state_d = S_DEAD;
            timer_d = DEAD_LD;
            nxt_d   = S_FWD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Bridge drive follows the current state; a disabled run forces the bridge off at once.
  always_comb begin
    en_a_d = 1'b0;
    en_b_d = 1'b0;
    pat_d  = 4'b0000;
    if (enable) begin
      case (state_q)
        S_FWD: begin
          pat_d = PAT_FWD;
          if (veerLeft) begin
            en_a_d = pwmVeer;
            en_b_d = pwmFull;
          end else if (veerRight) begin
            en_a_d = pwmFull;
            en_b_d = pwmVeer;
          end else begin
            en_a_d = pwmFull;
            en_b_d = pwmFull;
          end
        end
        S_REV: begin
          pat_d  = PAT_REV;
          en_a_d = pwmVeer;
          en_b_d = pwmVeer;
        end
        S_PIV: begin
          pat_d  = pdir_q ? PAT_PIVR : PAT_PIVL;
          en_a_d = pwmVeer;
          en_b_d = pwmVeer;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_DEAD) || (state_d == S_REV) || (state_d == S_PIV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      nxt_q   <= S_FWD;
      timer_q <= '0;
      plen_q  <= '0;
      pdir_q  <= 1'b1;
      en_a_q  <= 1'b0;
      en_b_q  <= 1'b0;
      pat_q   <= 4'b0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nxt_q   <= nxt_d;
      timer_q <= timer_d;
      plen_q  <= plen_d;
      pdir_q  <= pdir_d;
      en_a_q  <= en_a_d;
      en_b_q  <= en_b_d;
      pat_q   <= pat_d;
      busy_q  <= busy_d;
    end
  end

`ifdef DRIVE_SEQ_PIVOT_ALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pivot_dir_q <= 1'b1;
      rec_q       <= 1'b0;
    end else begin
      pivot_dir_q <= pivot_dir_d;
      rec_q       <= rec_d;
    end
  end
`endif

  assign hbEnA    = en_a_q;
  assign hbEnB    = en_b_q;
  assign hbIn1    = pat_q[3];
  assign hbIn2    = pat_q[2];
  assign hbIn3    = pat_q[1];
  assign hbIn4    = pat_q[0];
  assign seqState = state_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: vector table of per-cycle inputs and expected state, scoreboard of outputs,
// dead-time watchdog, plus hand-written reset sequences.
module tb_drive_sequencer;

  localparam int DEAD = 2, REV = 5, PIV = 4, TURN = 6;
`ifdef DRIVE_SEQ_PIVOT_ALT_EN
  localparam logic ALT = 1'b1;
`else
  localparam logic ALT = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic enable = 0, collision = 0, veerLeft = 0, veerRight = 0, junction = 0, turnDir = 0;
  logic pwmFull = 1'b1, pwmVeer = 1'b0;
  logic hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4, busy;
  logic [2:0] seqState;

  drive_sequencer #(
    .DEAD_CYCLES(DEAD), .REVERSE_CYCLES(REV), .PIVOT_CYCLES(PIV), .TURN_CYCLES(TURN), .TIMER_W(26)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .collision(collision), .veerLeft(veerLeft),
    .veerRight(veerRight), .junction(junction), .turnDir(turnDir), .pwmFull(pwmFull),
    .pwmVeer(pwmVeer), .hbEnA(hbEnA), .hbEnB(hbEnB), .hbIn1(hbIn1), .hbIn2(hbIn2),
    .hbIn3(hbIn3), .hbIn4(hbIn4), .seqState(seqState), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] in;   // {en, col, vl, vr, jn, td}
    logic [2:0] st;   // expected seqState after the edge
    logic       pd;   // expected pivot direction while st is PIVOT
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic       busy;
    logic [5:0] hb;   // {EnA, EnB, In1..In4}
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0, errors = 0;
  logic [2:0] prev_st = 3'd0;
  logic       prev_pd = 1'b1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add(input logic [5:0] in, input logic [2:0] st, input logic pd, input int n);
    vec_t v;
    v.in = in; v.st = st; v.pd = pd;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  // Bridge outputs expected after an edge, from the state held before it and the inputs at it.
  function automatic logic [5:0] hb_model(input logic [2:0] st, input logic pd, input logic [5:0] in,
                                          input logic pv);
    logic en, vl, vr;
    en = in[5]; vl = in[3]; vr = in[2];
    if (!en) return 6'b0;
    case (st)
      3'd1: begin
        if (vl)      return {pv, 1'b1, 4'b0110};
        else if (vr) return {1'b1, pv, 4'b0110};
        else         return {2'b11, 4'b0110};
      end
      3'd3:    return {pv, pv, 4'b1001};
      3'd4:    return {pv, pv, pd ? 4'b0101 : 4'b1010};
      default: return 6'b0;
    endcase
  endfunction

  task automatic run_table();
    exp_t e;
    for (int i = 0; i < vecs.size(); i++) begin
      {enable, collision, veerLeft, veerRight, junction, turnDir} = vecs[i].in;
      pwmVeer = ~pwmVeer;
      e.st   = vecs[i].st;
      e.busy = vecs[i].st inside {3'd2, 3'd3, 3'd4};
      e.hb   = hb_model(prev_st, prev_pd, vecs[i].in, pwmVeer);
      sb.push_back(e);
      prev_st = vecs[i].st;
      prev_pd = vecs[i].pd;
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    chk("scoreboard_drained", 8'(sb.size()), 8'd0);
  endtask

  // Scoreboard consumer plus a watchdog for direction changes without dead-time.
  exp_t       em;
  logic [3:0] last_dir = 4'b0, cur_dir;
  int         off_cnt = 0;
  always begin
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      em = sb.pop_front();
      chk("seqState", 8'(seqState), 8'(em.st));
      chk("busy_hb", {1'b0, busy, hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4}, {1'b0, em.busy, em.hb});
    end
    cur_dir = {hbIn1, hbIn2, hbIn3, hbIn4};
    if (seqState == 3'd0) last_dir = 4'b0;
    if (cur_dir == 4'b0) off_cnt++;
    else begin
      if (last_dir != 4'b0 && cur_dir != last_dir) begin
        checks++;
        if (off_cnt < DEAD) begin
          errors++;
          $display("FAIL dead_time: direction %b->%b after %0d off cycles, need %0d", last_dir, cur_dir,
                   off_cnt, DEAD);
        end
      end
      last_dir = cur_dir;
      off_cnt  = 0;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_state", 8'(seqState), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_hb", {2'b0, hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4}, 8'd0);
    rst = 1'b0;

    // cruise and veer
    add(6'b100000, 1, 1, 1);
    add(6'b100000, 1, 1, 2);
    add(6'b101000, 1, 1, 3);
    add(6'b101100, 1, 1, 3);
    add(6'b100100, 1, 1, 3);
    // single-cycle collision: first recovery pivots right
    add(6'b110000, 2, 1, 1);
    add(6'b100000, 2, 1, 1);
    add(6'b100000, 3, 1, REV);
    add(6'b100000, 2, 1, DEAD);
    add(6'b100000, 4, 1, PIV);
    add(6'b100000, 2, 1, DEAD);
    add(6'b100000, 1, 1, 2);
    // left junction turn, collision during the pivot is ignored
    add(6'b100010, 2, 0, 1);
    add(6'b100000, 2, 0, 1);
    add(6'b100000, 4, 0, 3);
    add(6'b110000, 4, 0, 1);
    add(6'b100000, 4, 0, 2);
    add(6'b100000, 2, 0, DEAD);
    add(6'b100000, 1, 1, 2);
    // right junction turn
    add(6'b100011, 2, 1, DEAD);
    add(6'b100000, 4, 1, TURN);
    add(6'b100000, 2, 1, DEAD);
    add(6'b100000, 1, 1, 2);
    // enable dropped mid-reverse, then straight back to forward
    add(6'b110000, 2, 1, DEAD);
    add(6'b100000, 3, 1, 2);
    add(6'b000000, 0, 1, 2);
    add(6'b100000, 1, 1, 2);
    // collision held: back-to-back recoveries
    add(6'b110000, 2, 1, DEAD);
    add(6'b110000, 3, 1, REV);
    add(6'b110000, 2, 1, DEAD);
    add(6'b110000, 4, !ALT, PIV);
    add(6'b110000, 2, 1, DEAD);
    add(6'b110000, 1, 1, 1);
    add(6'b110000, 2, 1, DEAD);
    add(6'b110000, 3, 1, REV);
    add(6'b110000, 2, 1, DEAD);
    add(6'b100000, 4, 1, PIV);
    add(6'b100000, 2, 1, DEAD);
    add(6'b100000, 1, 1, 2);
    run_table();

    // async reset while cruising takes effect before the next edge
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", 8'(seqState), 8'd0);
    chk("async_rst_busy", 8'(busy), 8'd0);
    chk("async_rst_hb", {2'b0, hbEnA, hbEnB, hbIn1, hbIn2, hbIn3, hbIn4}, 8'd0);
    enable = 1'b0; collision = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    prev_st = 3'd0;
    prev_pd = 1'b1;

    // after reset the next recovery pivots right again
    vecs.delete();
    add(6'b100000, 1, 1, 2);
    add(6'b110000, 2, 1, 1);
    add(6'b100000, 2, 1, 1);
    add(6'b100000, 3, 1, REV);
    add(6'b100000, 2, 1, DEAD);
    add(6'b100000, 4, 1, PIV);
    add(6'b100000, 2, 1, DEAD);
    add(6'b100000, 1, 1, 2);
    run_table();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
